// File: rtl/aes_word_loader.sv
// aes_word_loader: word-stream front end for the AES-128 encrypt core.
//   Collects key and plaintext as 32-bit valid/ready words (key first, MSW first),
//   pulses e_int for one cycle, holds key/plaintext stable while waiting for e_done,
//   then streams the captured ciphertext out as four 32-bit valid/ready words.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_data/in_valid/in_ready input word stream
//   key, plaintext, e_int     operands and start pulse to the core
//   ciphertext, e_done        result and completion strobe from the core
//   out_data/out_valid/out_ready  output word stream
//   busy                      high outside the load phase
//   timeout_err               sticky: the core did not finish within TIMEOUT cycles
//   reuse_key                 only when KEY_CACHE_EN is defined
// Optional feature: define KEY_CACHE_EN to allow plaintext-only transactions that reuse
// the previously loaded key.
module aes_word_loader #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TCNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         e_int,
  input  logic [127:0] ciphertext,
  input  logic         e_done,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         timeout_err
`ifdef KEY_CACHE_EN
  ,
  input  logic         reuse_key
`endif
);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StDrain} state_e;

  state_e              state_q, state_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [1:0]          ocnt_q, ocnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [127:0]        key_q, key_d;
  logic [127:0]        pt_q, pt_d;
  logic [127:0]        obuf_q, obuf_d;
  logic                terr_q, terr_d;
`ifdef KEY_CACHE_EN
  logic                key_ok_q, key_ok_d;
`endif

  logic       accept;
  logic [2:0] idx;
  logic [1:0] slot;
  logic       timeout_hit;

  assign accept = in_valid && (state_q == StLoad);
`ifdef KEY_CACHE_EN
  // A cached key lets word 0 land directly in the plaintext slots.
  assign idx = (wcnt_q == 3'd0 && reuse_key && key_ok_q) ? 3'd4 : wcnt_q;
`else
  assign idx = wcnt_q;
`endif
  // Word 0 of each half goes to the top 32 bits.
  assign slot = ~idx[1:0];
  assign timeout_hit = (state_q == StWait) && !e_done &&
                       (tcnt_q == TCNT_W'(TIMEOUT - 1));

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      wcnt_q   <= '0;
      ocnt_q   <= '0;
      tcnt_q   <= '0;
      key_q    <= '0;
      pt_q     <= '0;
      obuf_q   <= '0;
      terr_q   <= 1'b0;
`ifdef KEY_CACHE_EN
      key_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ocnt_q   <= ocnt_d;
      tcnt_q   <= tcnt_d;
      key_q    <= key_d;
      pt_q     <= pt_d;
      obuf_q   <= obuf_d;
      terr_q   <= terr_d;
`ifdef KEY_CACHE_EN
      key_ok_q <= key_ok_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (accept && idx == 3'd7) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        // e_done takes priority over a timeout in the same cycle.
        if (e_done)           state_d = StDrain;
        else if (timeout_hit) state_d = StLoad;
      end
      StDrain: if (out_ready && ocnt_q == 2'd3) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Datapath next values.
  always_comb begin
    wcnt_d   = wcnt_q;
    ocnt_d   = ocnt_q;
    tcnt_d   = tcnt_q;
    key_d    = key_q;
    pt_d     = pt_q;
    obuf_d   = obuf_q;
    terr_d   = terr_q;
`ifdef KEY_CACHE_EN
    key_ok_d = key_ok_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (idx[2]) pt_d[{slot, 5'd0} +: 32]  = in_data;
          else        key_d[{slot, 5'd0} +: 32] = in_data;
          // Wraps to 0 after the last word, ready for the next transaction.
          wcnt_d = idx + 3'd1;
`ifdef KEY_CACHE_EN
          if (idx == 3'd7 && wcnt_q == 3'd7) key_ok_d = 1'b1;
`endif
        end
      end
      StStart: tcnt_d = '0;
      StWait: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (e_done) begin
          obuf_d = ciphertext;
          ocnt_d = '0;
        end else if (timeout_hit) begin
          terr_d = 1'b1;
          wcnt_d = '0;
`ifdef KEY_CACHE_EN
          key_ok_d = 1'b0;
`endif
        end
      end
      StDrain: if (out_ready) ocnt_d = ocnt_q + 2'd1;
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready    = (state_q == StLoad);
    e_int       = (state_q == StStart);
    out_valid   = (state_q == StDrain);
    busy        = (state_q != StLoad);
    key         = key_q;
    plaintext   = pt_q;
    timeout_err = terr_q;
    out_data    = obuf_q[{~ocnt_q, 5'd0} +: 32];
  end

endmodule

// File: tb/tb_aes_word_loader.sv
module tb_aes_word_loader;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned TCNT_W  = 6;
`ifdef KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk, rst;
  logic [31:0]  in_data;
  logic         in_valid, in_ready;
  logic [127:0] key, plaintext, ciphertext;
  logic         e_int, e_done;
  logic [31:0]  out_data;
  logic         out_valid, out_ready, busy, timeout_err, reuse_key;

  aes_word_loader #(.TIMEOUT(TIMEOUT), .TCNT_W(TCNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .plaintext(plaintext), .e_int(e_int), .ciphertext(ciphertext),
    .e_done(e_done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
`ifdef KEY_CACHE_EN
    , .reuse_key(reuse_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0]  exp_q[$];
  logic [127:0] mdl_key = '0;
  bit           mdl_key_ok = 1'b0;
  logic         mdl_terr = 1'b0;
  logic [127:0] exp_key, exp_pt;
  bit           stub_hang = 1'b0;
  int           stub_lat = 1;
  int           ready_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Core behaviour: the FIPS-197 vector, otherwise an arbitrary mix of key and plaintext.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {k[63:0], k[127:64]} ^ p ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Core stub: checks operands at the start pulse, answers after stub_lat WAIT cycles.
  initial begin
    logic [127:0] k, p;
    e_done = 1'b0;
    ciphertext = '0;
    forever begin
      @(negedge clk);
      if (e_int && !rst) begin
        chk("key_at_start", key, exp_key);
        chk("pt_at_start", plaintext, exp_pt);
        if (!stub_hang) begin
          k = key;
          p = plaintext;
          repeat (stub_lat) @(posedge clk);
          #1;
          e_done = 1'b1;
          ciphertext = core_fn(k, p);
          @(negedge clk);
          chk("key_stable", key, k);
          chk("pt_stable", plaintext, p);
          @(posedge clk); #1;
          e_done = 1'b0;
          ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every transfer, checks stall stability.
  initial begin
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) chk("stall_hold", {96'b0, out_data}, {96'b0, prev_data});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected no word", out_data);
          end else begin
            w = exp_q.pop_front();
            chk("out_data", {96'b0, out_data}, {96'b0, w});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] w, input logic rk);
    int n = 0;
    logic rdy;
    in_data = w;
    in_valid = 1'b1;
    reuse_key = rk;
    do begin
      @(negedge clk);
      rdy = in_ready;
      chkb("no_early_e_int", e_int, 1'b0);
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
    reuse_key = 1'($urandom_range(1));
    in_data = $urandom();
  endtask

  // mode: 0 normal, 1 core hangs (timeout), 2 core hangs and reset in WAIT,
  //       3 normal with a 5-cycle output stall on the first word.
  task automatic do_txn(input logic [127:0] k, input logic [127:0] p, input logic rk,
                        input int mode, input int lat, input int gap);
    logic [31:0] words[$];
    logic [127:0] ct;
    bit eff;
    int n;
    eff = CACHE && rk && mdl_key_ok;
    if (!eff) begin
      mdl_key = k;
      mdl_key_ok = 1'b1;
      for (int i = 0; i < 4; i++) words.push_back(k[127-32*i -: 32]);
    end
    for (int i = 0; i < 4; i++) words.push_back(p[127-32*i -: 32]);
    exp_key = mdl_key;
    exp_pt = p;
    stub_hang = (mode == 1 || mode == 2);
    stub_lat = lat;
    if (!stub_hang) begin
      ct = core_fn(mdl_key, p);
      for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
    end
    if (mode == 3) ready_mode = 1;
    for (int i = 0; i < words.size(); i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      send_word(words[i], (i == 0) ? rk : 1'($urandom_range(1)));
    end
    @(negedge clk);
    chkb("e_int_after_last", e_int, 1'b1);
    @(negedge clk);
    chkb("e_int_one_cycle", e_int, 1'b0);
    if (mode == 1) begin
      n = 1;
      if (mdl_terr == 1'b0) begin
        while (!timeout_err && n < 200) begin @(negedge clk); n++; end
        chkb("timeout_latency", (n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 1), 1'b1);
      end
      while (busy && n < 200) begin @(negedge clk); n++; end
      mdl_terr = 1'b1;
      mdl_key_ok = 1'b0;
      chkb("timeout_err_set", timeout_err, 1'b1);
      chkb("timeout_busy", busy, 1'b0);
      chkb("timeout_in_ready", in_ready, 1'b1);
    end else if (mode == 2) begin
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_key", key, '0);
      chk("rst_pt", plaintext, '0);
      chk("rst_out_data", {96'b0, out_data}, '0);
      chkb("rst_e_int", e_int, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_terr", timeout_err, 1'b0);
      chkb("rst_in_ready", in_ready, 1'b1);
      mdl_terr = 1'b0;
      mdl_key_ok = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      if (mode == 3) begin
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chkb("stall_valid_seen", out_valid, 1'b1);
        repeat (5) begin
          @(negedge clk);
          if (exp_q.size() > 0) chk("stall_first_word", {96'b0, out_data}, {96'b0, exp_q[0]});
          chkb("stall_out_valid", out_valid, 1'b1);
          chkb("stall_in_ready", in_ready, 1'b0);
        end
        ready_mode = 2;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); #2; n++; end
      chkb("drain_complete", (exp_q.size() == 0), 1'b1);
      @(negedge clk);
      chkb("zero_bubble_in_ready", in_ready, 1'b1);
      chkb("idle_busy", busy, 1'b0);
      chkb("terr_level", timeout_err, mdl_terr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    reuse_key = 1'b0;
    #12;
    chkb("reset_in_ready", in_ready, 1'b1);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_e_int", e_int, 1'b0);
    chkb("reset_out_valid", out_valid, 1'b0);
    chkb("reset_terr", timeout_err, 1'b0);
    chk("reset_key", key, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 vector, immediate and edge-case core latencies.
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, 5, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 3, 3, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, 4, 1);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, 1, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, TIMEOUT, 0);

    // Randomized traffic.
    ready_mode = 0;
    for (int t = 0; t < 10; t++)
      do_txn({$urandom(), $urandom(), $urandom(), $urandom()},
             {$urandom(), $urandom(), $urandom(), $urandom()},
             1'b0, 0, $urandom_range(13, 1), $urandom_range(2));

    // Timeout, then a normal load with the sticky flag still set.
    do_txn({$urandom(), $urandom(), $urandom(), $urandom()}, FIPS_PT, 1'b0, 1, 1, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, 6, 0);

    // Reset in WAIT, then the FIPS vector again.
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 2, 1, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b0, 0, 5, 0);

    // Key reuse; without the cache every transaction is a full load.
    do_txn(FIPS_KEY, FIPS_PT, 1'b1, 0, 7, 0);
    do_txn({$urandom(), $urandom(), $urandom(), $urandom()},
           {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 0, 2, 1);
    do_txn({$urandom(), $urandom(), $urandom(), $urandom()}, FIPS_PT, 1'b0, 1, 1, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b1, 0, 3, 0);
    do_txn(FIPS_KEY, FIPS_PT, 1'b1, 0, 9, 2);

    repeat (3) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
